jtag_tap_regs: RTL and testbench



---
 rtl/jtag_tap_regs_pkg.sv | 11 +
 rtl/jtag_shift_reg.sv | 28 ++
 rtl/jtag_tap_regs.sv | 93 +++++++++
 tb/tb_jtag_tap_regs.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_regs_pkg.sv
// jtag_tap_regs_pkg: shared opcodes, IR capture pattern and DR select type for the TAP register block.
// Optional feature macro: JTAG_TAP_USERCODE_EN (adds the USERCODE opcode default).
package jtag_tap_regs_pkg;
   localparam logic [4:0] IR_IDCODE_DEF = 5'h01;
   localparam logic [4:0] IR_DBG_DEF    = 5'h08;
`ifdef JTAG_TAP_USERCODE_EN
   localparam logic [4:0] IR_USERCODE_DEF = 5'h07;
`endif
   localparam logic [1:0] IR_CAPTURE = 2'b01;
   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DBG, DR_USERCODE} dr_sel_t;
endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: capture/shift register with a parallel update latch.
// Ports: tck clock; rstn sync active-low clear; capture loads pin; shift moves sin in at the MSB;
//        update copies the shift register to pout; sout is the shift register LSB.
module jtag_shift_reg #(
   parameter int            W        = 5,
   parameter logic [W-1:0]  UPD_INIT = '0
) (
   input  logic         tck,
   input  logic         rstn,
   input  logic         capture,
   input  logic         shift,
   input  logic         update,
   input  logic         sin,
   input  logic [W-1:0] pin,
   output logic [W-1:0] pout,
   output logic         sout
);
   logic [W-1:0] sh;
   assign sout = sh[0];
   always_ff @(posedge tck) begin
      if (!rstn) begin
         sh   <= '0;
         pout <= UPD_INIT;
      end else if (update) pout <= sh;
      else if (capture) sh <= pin;
      else if (shift) sh <= {sin, sh[W-1:1]};
   end
endmodule

// File: rtl/jtag_tap_regs.sv
// jtag_tap_regs: JTAG instruction register plus BYPASS, IDCODE and DBG data registers driven by TAP state strobes.
// Ports: tck clock; trstn sync active-low reset; tdi serial in; st_* decoded TAP state strobes;
//        tdo/tdo_oe serial out and enable; ir latched instruction; dbg_capture_data/dbg_capture
//        parallel capture and pulse; dbg_update_data/dbg_update parallel update and pulse.
// Optional feature macro: JTAG_TAP_USERCODE_EN (USERCODE data register on IR_USERCODE).
module jtag_tap_regs
   import jtag_tap_regs_pkg::*;
#(
   parameter int                  IR_WIDTH   = 5,
   parameter int                  DR_WIDTH   = 32,
   parameter logic [31:0]         IDCODE_VAL = 32'h1BEEF001,
   parameter logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IR_IDCODE_DEF),
   parameter logic [IR_WIDTH-1:0] IR_DBG     = IR_WIDTH'(IR_DBG_DEF),
   parameter logic [IR_WIDTH-1:0] IR_BYPASS  = '1
`ifdef JTAG_TAP_USERCODE_EN
   ,
   parameter logic [IR_WIDTH-1:0] IR_USERCODE  = IR_WIDTH'(IR_USERCODE_DEF),
   parameter logic [31:0]         USERCODE_VAL = 32'h0
`endif
) (
   input  logic                tck,
   input  logic                trstn,
   input  logic                tdi,
   input  logic                st_test_logic_reset,
   input  logic                st_capture_dr,
   input  logic                st_shift_dr,
   input  logic                st_update_dr,
   input  logic                st_capture_ir,
   input  logic                st_shift_ir,
   input  logic                st_update_ir,
   output logic                tdo,
   output logic                tdo_oe,
   output logic [IR_WIDTH-1:0] ir,
   input  logic [DR_WIDTH-1:0] dbg_capture_data,
   output logic                dbg_capture,
   output logic [DR_WIDTH-1:0] dbg_update_data,
   output logic                dbg_update
);
   dr_sel_t             sel;
   logic                rstn, any_upd, any_cap, cap_ir, sh_ir, cap_dr, sh_dr;
   logic                dr_used, is_dbg, ir_so, dr_so, byp;
   logic [DR_WIDTH-1:0] dr_pin;
   assign rstn    = trstn & ~st_test_logic_reset;
   // strobes should be one-hot; if not, update beats capture beats shift
   assign any_upd = st_update_dr | st_update_ir;
   assign any_cap = st_capture_dr | st_capture_ir;
   assign cap_ir  = st_capture_ir & ~any_upd;
   assign cap_dr  = st_capture_dr & ~any_upd;
   assign sh_ir   = st_shift_ir & ~any_upd & ~any_cap;
   assign sh_dr   = st_shift_dr & ~any_upd & ~any_cap;
   always_comb begin
      sel = DR_BYPASS;
      if (ir == IR_IDCODE) sel = DR_IDCODE;
      else if (ir == IR_DBG) sel = DR_DBG;
`ifdef JTAG_TAP_USERCODE_EN
      else if (ir == IR_USERCODE) sel = DR_USERCODE;
`endif
      else if (ir == IR_BYPASS) sel = DR_BYPASS;
   end
   assign dr_used = sel != DR_BYPASS;
   assign is_dbg  = sel == DR_DBG;
   always_comb begin
      dr_pin = '0;
      if (sel == DR_IDCODE) dr_pin = DR_WIDTH'(IDCODE_VAL);
      else if (sel == DR_DBG) dr_pin = dbg_capture_data;
`ifdef JTAG_TAP_USERCODE_EN
      else if (sel == DR_USERCODE) dr_pin = DR_WIDTH'(USERCODE_VAL);
`endif
   end
   jtag_shift_reg #(.W(IR_WIDTH), .UPD_INIT(IR_IDCODE)) u_ir (
      .tck(tck), .rstn(rstn), .capture(cap_ir), .shift(sh_ir), .update(st_update_ir),
      .sin(tdi), .pin(IR_WIDTH'(IR_CAPTURE)), .pout(ir), .sout(ir_so)
   );
   // one DR shift register shared by IDCODE, DBG and USERCODE; only DBG exposes its update latch
   jtag_shift_reg #(.W(DR_WIDTH), .UPD_INIT('0)) u_dr (
      .tck(tck), .rstn(rstn), .capture(cap_dr & dr_used), .shift(sh_dr & dr_used),
      .update(st_update_dr & is_dbg), .sin(tdi), .pin(dr_pin), .pout(dbg_update_data), .sout(dr_so)
   );
   always_ff @(posedge tck) begin
      if (!rstn) begin
         byp         <= 1'b0;
         dbg_capture <= 1'b0;
         dbg_update  <= 1'b0;
      end else begin
         dbg_capture <= cap_dr & is_dbg;
         dbg_update  <= st_update_dr & is_dbg;
         if (cap_dr & ~dr_used) byp <= 1'b0;
         else if (sh_dr & ~dr_used) byp <= tdi;
      end
   end
   assign tdo    = st_shift_ir ? ir_so : st_shift_dr ? (dr_used ? dr_so : byp) : 1'b0;
   assign tdo_oe = st_shift_ir | st_shift_dr;
endmodule

// File: tb/tb_jtag_tap_regs.sv
// tb_jtag_tap_regs: randomized scans of jtag_tap_regs checked against a scan-level model.
module tb_jtag_tap_regs;
  localparam logic [31:0] IDC = 32'h1BEEF001;
  localparam logic [31:0] UC  = 32'hCAFE0001;
  localparam int IDLE = 0, CAPDR = 1, SHDR = 2, UPDDR = 3, CAPIR = 4, SHIR = 5, UPDIR = 6, TLR = 7;
  logic tck = 1'b0, trstn = 1'b0, tdi = 1'b0;
  logic st_test_logic_reset = 1'b0, st_capture_dr = 1'b0, st_shift_dr = 1'b0, st_update_dr = 1'b0;
  logic st_capture_ir = 1'b0, st_shift_ir = 1'b0, st_update_ir = 1'b0;
  logic tdo, tdo_oe, dbg_capture, dbg_update;
  logic [4:0]  ir;
  logic [31:0] dbg_capture_data = '0, dbg_update_data;
  int tests = 0, fails = 0, ncap = 0, nupd = 0, oe_bad = 0;
  logic tdo_s;
  logic [31:0] model_upd = '0;
`ifdef JTAG_TAP_USERCODE_EN
  jtag_tap_regs #(.USERCODE_VAL(UC)) dut (.*);
`else
  jtag_tap_regs dut (.*);
`endif
  always #5 tck = ~tck;
  function automatic int dr_len(input logic [4:0] op);
    if (op == 5'h01 || op == 5'h08) return 32;
`ifdef JTAG_TAP_USERCODE_EN
    if (op == 5'h07) return 32;
`endif
    return 1;
  endfunction
  function automatic logic [31:0] dr_cap(input logic [4:0] op, input logic [31:0] cap);
    if (op == 5'h01) return IDC;
    if (op == 5'h08) return cap;
`ifdef JTAG_TAP_USERCODE_EN
    if (op == 5'h07) return UC;
`endif
    return 32'h0;
  endfunction
  function automatic logic [127:0] nmask(input int n);
    return (128'b1 << n) - 128'b1;
  endfunction
  function automatic logic [127:0] exp_stream(input logic [4:0] op, input logic [31:0] cap,
                                              input logic [127:0] din, input int n);
    return ((din << dr_len(op)) | {96'b0, dr_cap(op, cap)}) & nmask(n);
  endfunction
  function automatic logic [31:0] dbg_after(input logic [31:0] cap, input logic [127:0] din, input int n);
    logic [127:0] s;
    s = ((din << 32) | {96'b0, cap}) >> n;
    return s[31:0];
  endfunction
  task automatic tap(input int st, input logic d);
    @(negedge tck);
    st_test_logic_reset = (st == TLR);
    st_capture_dr = (st == CAPDR);
    st_shift_dr   = (st == SHDR);
    st_update_dr  = (st == UPDDR);
    st_capture_ir = (st == CAPIR);
    st_shift_ir   = (st == SHIR);
    st_update_ir  = (st == UPDIR);
    tdi = d;
    #1;
    tdo_s = tdo;
    if (tdo_oe !== ((st == SHDR) || (st == SHIR))) oe_bad++;
    if (dbg_capture === 1'b1) ncap++;
    if (dbg_update === 1'b1) nupd++;
  endtask
  task automatic ir_scan(input logic [4:0] op, output logic [4:0] q);
    q = '0;
    tap(CAPIR, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tap(SHIR, op[i]);
      q[i] = tdo_s;
    end
    tap(UPDIR, 1'b0);
    tap(IDLE, 1'b0);
  endtask
  task automatic dr_scan(input int n, input logic [127:0] din, input bit pause, output logic [127:0] q);
    q = '0;
    ncap = 0;
    nupd = 0;
    tap(CAPDR, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (pause && $urandom_range(0, 2) == 0) tap(IDLE, 1'b0);
      tap(SHDR, din[i]);
      q[i] = tdo_s;
    end
    tap(UPDDR, 1'b0);
    tap(IDLE, 1'b0);
    tap(IDLE, 1'b0);
  endtask
  task automatic test_reset;
    trstn = 1'b0;
    tap(IDLE, 1'b0);
    tap(IDLE, 1'b0);
    trstn = 1'b1;
    tap(IDLE, 1'b0);
    model_upd = '0;
    tests++; if (ir !== 5'h01) begin fails++; $display("FAIL reset_ir: got %h want 01", ir); end
    tests++; if ({tdo, tdo_oe} !== 2'b00) begin fails++; $display("FAIL reset_tdo: got %b want 00", {tdo, tdo_oe}); end
    tests++; if ({dbg_capture, dbg_update} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {dbg_capture, dbg_update}); end
    tests++; if (dbg_update_data !== 32'h0) begin fails++; $display("FAIL reset_upd_data: got %h want 0", dbg_update_data); end
  endtask
  task automatic test_idcode;
    logic [127:0] q;
    oe_bad = 0;
    dr_scan(32, '0, 1'b0, q);
    tests++; if (q[31:0] !== IDC) begin fails++; $display("FAIL idcode_stream: got %h want %h", q[31:0], IDC); end
    tests++; if (oe_bad !== 0) begin fails++; $display("FAIL idcode_oe: got %0d bad cycles want 0", oe_bad); end
    tests++; if (ncap + nupd !== 0) begin fails++; $display("FAIL idcode_pulses: got %0d want 0", ncap + nupd); end
  endtask
  task automatic test_ir_scan;
    logic [4:0] q;
    oe_bad = 0;
    ir_scan(5'h08, q);
    tests++; if (q !== 5'b00001) begin fails++; $display("FAIL ir_capture: got %b want 00001", q); end
    tests++; if (ir !== 5'h08) begin fails++; $display("FAIL ir_update: got %h want 08", ir); end
    tests++; if (oe_bad !== 0) begin fails++; $display("FAIL ir_oe: got %0d bad cycles want 0", oe_bad); end
  endtask
  task automatic test_dbg;
    logic [127:0] q, din, e;
    logic [31:0] cap;
    for (int k = 0; k < 6; k++) begin
      cap = (k == 0) ? 32'hA5A5_0F0F : $urandom;
      din = (k == 0) ? 128'h1234_5678 : {96'b0, $urandom};
      dbg_capture_data = cap;
      dr_scan(32, din, k > 0, q);
      e = exp_stream(5'h08, cap, din, 32);
      model_upd = dbg_after(cap, din, 32);
      tests++; if (q !== e) begin fails++; $display("FAIL dbg_stream[%0d]: got %h want %h", k, q[31:0], e[31:0]); end
      tests++; if (ncap !== 1 || nupd !== 1) begin fails++; $display("FAIL dbg_pulses[%0d]: got cap=%0d upd=%0d want 1/1", k, ncap, nupd); end
      tests++; if (dbg_update_data !== model_upd) begin fails++; $display("FAIL dbg_update_data[%0d]: got %h want %h", k, dbg_update_data, model_upd); end
    end
  endtask
  task automatic test_bypass;
    logic [4:0] qi, op;
    logic [127:0] q, din, e;
    int n;
    ir_scan(5'h1F, qi);
    din = 128'b1011_0011;
    dr_scan(8, din, 1'b0, q);
    e = exp_stream(5'h1F, '0, din, 8);
    tests++; if (q !== e) begin fails++; $display("FAIL bypass_fixed: got %h want %h", q[7:0], e[7:0]); end
    for (int k = 0; k < 4; k++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'h01 || op == 5'h08);
      ir_scan(op, qi);
      n = $urandom_range(8, 20);
      din = {64'b0, $urandom, $urandom} & nmask(n);
      dr_scan(n, din, 1'b1, q);
      e = exp_stream(op, '0, din, n);
      tests++; if (q !== e) begin fails++; $display("FAIL bypass_op%h: got %h want %h", op, q[31:0], e[31:0]); end
      tests++; if (nupd !== 0 || dbg_update_data !== model_upd) begin fails++; $display("FAIL bypass_noupd_op%h: got upd=%0d data=%h want 0/%h", op, nupd, dbg_update_data, model_upd); end
    end
  endtask
  task automatic test_usercode;
    logic [4:0] qi;
    logic [127:0] q, din, e;
    ir_scan(5'h07, qi);
    din = {96'b0, $urandom};
    dr_scan(32, din, 1'b0, q);
    e = exp_stream(5'h07, '0, din, 32);
    tests++; if (q !== e) begin fails++; $display("FAIL usercode_stream: got %h want %h", q[31:0], e[31:0]); end
  endtask
  task automatic test_long_shift;
    logic [4:0] qi;
    logic [127:0] q, din, e;
    logic [31:0] cap;
    ir_scan(5'h01, qi);
    din = {64'b0, $urandom, $urandom} & nmask(40);
    dr_scan(40, din, 1'b0, q);
    e = exp_stream(5'h01, '0, din, 40);
    tests++; if (q !== e) begin fails++; $display("FAIL long_idcode: got %h want %h", q[39:0], e[39:0]); end
    ir_scan(5'h08, qi);
    cap = $urandom;
    dbg_capture_data = cap;
    din = {64'b0, $urandom, $urandom} & nmask(45);
    dr_scan(45, din, 1'b1, q);
    e = exp_stream(5'h08, cap, din, 45);
    model_upd = dbg_after(cap, din, 45);
    tests++; if (q !== e) begin fails++; $display("FAIL long_dbg: got %h want %h", q[44:0], e[44:0]); end
    tests++; if (dbg_update_data !== model_upd) begin fails++; $display("FAIL long_dbg_upd: got %h want %h", dbg_update_data, model_upd); end
  endtask
  task automatic test_abort;
    logic [4:0] qi;
    trstn = 1'b0;
    tap(IDLE, 1'b0);
    trstn = 1'b1;
    model_upd = '0;
    ir_scan(5'h08, qi);
    dbg_capture_data = $urandom;
    ncap = 0;
    nupd = 0;
    tap(CAPDR, 1'b0);
    for (int i = 0; i < 10; i++) tap(SHDR, 1'($urandom_range(0, 1)));
    trstn = 1'b0;
    tap(SHDR, 1'b1);
    trstn = 1'b1;
    tap(IDLE, 1'b0);
    tap(IDLE, 1'b0);
    tests++; if (ir !== 5'h01) begin fails++; $display("FAIL abort_ir: got %h want 01", ir); end
    tests++; if (nupd !== 0) begin fails++; $display("FAIL abort_update_pulse: got %0d want 0", nupd); end
    tests++; if (dbg_update_data !== model_upd) begin fails++; $display("FAIL abort_upd_data: got %h want %h", dbg_update_data, model_upd); end
  endtask
  task automatic test_tlr;
    logic [4:0] qi;
    ir_scan(5'h08, qi);
    tests++; if (ir !== 5'h08) begin fails++; $display("FAIL tlr_pre_ir: got %h want 08", ir); end
    tap(TLR, 1'b0);
    tap(IDLE, 1'b0);
    tests++; if (ir !== 5'h01) begin fails++; $display("FAIL tlr_ir: got %h want 01", ir); end
  endtask
  initial begin
    test_reset;
    test_idcode;
    test_ir_scan;
    test_dbg;
    test_bypass;
    test_usercode;
    test_long_shift;
    test_abort;
    test_tlr;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
